difftest_debug_mode_buffer: RTL

- Multi-core, change-filtered successor to the per-cycle debug-mode difftest probe.
- Watches debug-mode CSR state (debugMode, dcsr, dpc, dscratch0/1) from NUM_CORES harts every cycle.
- Captures a record only when a hart's state differs from its last captured state, and buffers records in a FIFO.
- Drains records over a valid/ready stream to the difftest batching sink, so the host sees events rather than one call per cycle.

---
 rtl/difftest_pkg.sv | 27 ++
 rtl/difftest_debug_mode_buffer_if.sv | 30 +++
 rtl/difftest_sync_fifo.sv | 57 +++++
 rtl/difftest_debug_mode_buffer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// Shared types and default widths for the difftest capture buffers.
package difftest_pkg;

  localparam int DT_NUM_CORES = 2;
  localparam int DT_DEPTH     = 8;
  localparam int DT_XLEN      = 64;
  localparam int DT_COREID_W  = 8;
  localparam int DT_TS_W      = 32;

  // One captured debug-mode event. Field order matches the flat record
  // layout used inside the buffer: {coreid, tuple, timestamp}.
  typedef struct packed {
    logic [DT_COREID_W-1:0] coreid;
    logic                   debugMode;
    logic [DT_XLEN-1:0]     dcsr;
    logic [DT_XLEN-1:0]     dpc;
    logic [DT_XLEN-1:0]     dscratch0;
    logic [DT_XLEN-1:0]     dscratch1;
    logic [DT_TS_W-1:0]     timestamp;
  } debug_mode_rec_t;

  // Saturating +1 for 32-bit event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/difftest_debug_mode_buffer_if.sv
// Output record stream of the debug-mode buffer (valid/ready, head record).
interface difftest_debug_mode_buffer_if
  import difftest_pkg::*;
#(
  parameter int XLEN     = DT_XLEN,
  parameter int COREID_W = DT_COREID_W,
  parameter int TS_W     = DT_TS_W
);
  logic                io_out_valid;
  logic                io_out_ready;
  logic [COREID_W-1:0] io_out_coreid;
  logic                io_out_debugMode;
  logic [XLEN-1:0]     io_out_dcsr;
  logic [XLEN-1:0]     io_out_dpc;
  logic [XLEN-1:0]     io_out_dscratch0;
  logic [XLEN-1:0]     io_out_dscratch1;
  logic [TS_W-1:0]     io_out_timestamp;

  modport master (
    output io_out_valid, io_out_coreid, io_out_debugMode, io_out_dcsr,
           io_out_dpc, io_out_dscratch0, io_out_dscratch1, io_out_timestamp,
    input  io_out_ready
  );

  modport slave (
    input  io_out_valid, io_out_coreid, io_out_debugMode, io_out_dcsr,
           io_out_dpc, io_out_dscratch0, io_out_dscratch1, io_out_timestamp,
    output io_out_ready
  );
endinterface

// File: rtl/difftest_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO, registered storage, head read
// directly from the storage array. Writes while full and reads while empty
// are ignored.
module difftest_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_fire, rd_fire;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_fire   = wr_en_i && !full_o;
  assign rd_fire   = rd_en_i && !empty_o;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/difftest_debug_mode_buffer.sv
// Multi-hart debug-mode CSR monitor. Each channel records its CSR tuple only
// when it differs from the last captured one; captures sit in a one-deep
// per-channel pending slot (latest wins, overwrites counted) and a
// round-robin arbiter moves one pending record per cycle into the FIFO.
module difftest_debug_mode_buffer
  import difftest_pkg::*;
#(
  parameter int NUM_CORES = DT_NUM_CORES,
  parameter int DEPTH     = DT_DEPTH,
  parameter int XLEN      = DT_XLEN,
  parameter int COREID_W  = DT_COREID_W,
  parameter int TS_W      = DT_TS_W
) (
  input  logic                          io_clock,
  input  logic                          io_reset,
  input  logic [NUM_CORES*COREID_W-1:0] io_coreid,
  input  logic [NUM_CORES-1:0]          io_valid,
  input  logic [NUM_CORES-1:0]          io_debugMode,
  input  logic [NUM_CORES*XLEN-1:0]     io_dcsr,
  input  logic [NUM_CORES*XLEN-1:0]     io_dpc,
  input  logic [NUM_CORES*XLEN-1:0]     io_dscratch0,
  input  logic [NUM_CORES*XLEN-1:0]     io_dscratch1,
  difftest_debug_mode_buffer_if.master  out_if,
  output logic [31:0]                   io_coalesce_cnt,
  output logic [$clog2(DEPTH):0]        io_count
);

  localparam int TUP_W = 1 + 4 * XLEN;
  localparam int REC_W = COREID_W + TUP_W + TS_W;
  localparam int GW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [TUP_W-1:0]     tuple      [NUM_CORES];
  logic [NUM_CORES-1:0] changed;

  logic [NUM_CORES-1:0] seen_q,   seen_d;
  logic [NUM_CORES-1:0] pend_v_q, pend_v_d;
  logic [TUP_W-1:0]     last_q    [NUM_CORES];
  logic [TUP_W-1:0]     last_d    [NUM_CORES];
  logic [REC_W-1:0]     pend_q    [NUM_CORES];
  logic [REC_W-1:0]     pend_d    [NUM_CORES];
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [31:0]          coal_q, coal_d;
  logic [TS_W-1:0]      ts_q;

  logic                 grant_v;
  logic [GW-1:0]        grant_idx;
  logic                 fifo_full, fifo_empty;
  logic [REC_W-1:0]     head;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_ch
    assign tuple[gi] = {io_debugMode[gi],
                        io_dcsr[gi*XLEN +: XLEN],
                        io_dpc[gi*XLEN +: XLEN],
                        io_dscratch0[gi*XLEN +: XLEN],
                        io_dscratch1[gi*XLEN +: XLEN]};
    assign changed[gi] = io_valid[gi] && (!seen_q[gi] || (tuple[gi] != last_q[gi]));
  end

  // Round-robin pick among pending channels, starting after the last grant;
  // a full FIFO blocks the grant even if the head leaves this cycle.
  always_comb begin
    int c;
    grant_v   = 1'b0;
    grant_idx = '0;
    c         = 0;
    if (!fifo_full) begin
      for (int k = 1; k <= NUM_CORES; k++) begin
        c = (int'(last_grant_q) + k) % NUM_CORES;
        if (!grant_v && pend_v_q[c]) begin
          grant_v   = 1'b1;
          grant_idx = GW'(c);
        end
      end
    end
  end

  // Change capture into the pending slots; an overwrite of an entry that is
  // not leaving this cycle is the only way a record is lost, and is counted.
  always_comb begin
    seen_d       = seen_q;
    pend_v_d     = pend_v_q;
    last_d       = last_q;
    pend_d       = pend_q;
    coal_d       = coal_q;
    last_grant_d = grant_v ? grant_idx : last_grant_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (changed[i]) begin
        last_d[i]   = tuple[i];
        seen_d[i]   = 1'b1;
        pend_d[i]   = {io_coreid[i*COREID_W +: COREID_W], tuple[i], ts_q};
        pend_v_d[i] = 1'b1;
        if (pend_v_q[i] && !(grant_v && (int'(grant_idx) == i))) begin
          coal_d = sat_inc32(coal_d);
        end
      end else if (grant_v && (int'(grant_idx) == i)) begin
        pend_v_d[i] = 1'b0;
      end
    end
  end

  // Control state: flags, arbiter pointer, coalesce counter, timestamp.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      seen_q       <= '0;
      pend_v_q     <= '0;
      last_grant_q <= GW'(NUM_CORES - 1);
      coal_q       <= '0;
      ts_q         <= '0;
    end else begin
      seen_q       <= seen_d;
      pend_v_q     <= pend_v_d;
      last_grant_q <= last_grant_d;
      coal_q       <= coal_d;
      ts_q         <= ts_q + TS_W'(1);
    end
  end

  // Captured data; qualified by seen/pend_v so it needs no reset.
  always_ff @(posedge io_clock) begin
    last_q <= last_d;
    pend_q <= pend_d;
  end

  difftest_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk_i     (io_clock),
    .rst_i     (io_reset),
    .wr_en_i   (grant_v),
    .wr_data_i (pend_q[grant_idx]),
    .rd_en_i   (out_if.io_out_valid && out_if.io_out_ready),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (io_count)
  );

  assign out_if.io_out_valid = !fifo_empty;
  assign {out_if.io_out_coreid, out_if.io_out_debugMode, out_if.io_out_dcsr,
          out_if.io_out_dpc, out_if.io_out_dscratch0, out_if.io_out_dscratch1,
          out_if.io_out_timestamp} = head;
  assign io_coalesce_cnt = coal_q;

endmodule
